seven_segment_mux: RTL and testbench

Parametrised time-multiplexed driver for common-anode seven-segment displays. It scans NUM_DIGITS hex digits and adds per-digit decimal points, per-digit blanking, leading-zero suppression and PWM brightness control. The input value is snapshotted once per frame, so a displayed frame never mixes old and new values. It sits between any debug or value source and the board's cathode and anode pins.

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seven_segment_mux.sv | 143 ++++++++++++++
 tb/tb_seven_segment_mux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: hex font, blank pattern and the
// leading-zero suppression mask helper.
package seg_pkg;

  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned FULL_W     = 4 * MAX_DIGITS;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high a..g patterns, entry i at HEX_FONT[i]
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Bit i set when digit i (i >= 1) and every digit above it hold zero
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [FULL_W-1:0] nibbles,
    input int unsigned       num_digits
  );
    logic                  all_zero;
    logic [MAX_DIGITS-1:0] mask;
    all_zero = 1'b1;
    mask     = '0;
    for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < num_digits) begin
        all_zero = all_zero & (nibbles[4*i +: 4] == 4'h0);
        mask[i]  = all_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low a..g segment decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_c_o
);

  assign seg_n_c_o = ~HEX_FONT[nibble_i];

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed common-anode seven-segment driver with per-frame input
// snapshot, blanking, leading-zero suppression and PWM brightness.
module seven_segment_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned COUNT_TO   = 100_000,
  parameter int unsigned BRIGHT_W   = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress_in,
  input  logic [BRIGHT_W-1:0]     brightness_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done_out
);

  localparam int unsigned DWELL_W = (COUNT_TO > 1) ? $clog2(COUNT_TO) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;

  logic [DWELL_W-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [BRIGHT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  first_q, first_d;
  logic [VAL_W-1:0]      sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
  logic                  sh_lz_q, sh_lz_d;
  logic [BRIGHT_W-1:0]   sh_bright_q, sh_bright_d;
  logic [6:0]            cat_q, cat_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0]            cur_nib_c;
  logic [6:0]            cur_seg_n_c;
  logic [NUM_DIGITS-1:0] lz_vec_c;

  assign cur_nib_c = sh_val_q[{digit_idx_q, 2'b00} +: 4];
  assign lz_vec_c  = NUM_DIGITS'(lz_mask(FULL_W'(sh_val_q), NUM_DIGITS));

  seg_hex_decode u_decode (
    .nibble_i  (cur_nib_c),
    .seg_n_c_o (cur_seg_n_c)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dwell_cnt_q  <= '0;
      digit_idx_q  <= '0;
      pwm_cnt_q    <= '0;
      first_q      <= 1'b1;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      sh_lz_q      <= 1'b0;
      sh_bright_q  <= '0;
      cat_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      dwell_cnt_q  <= dwell_cnt_d;
      digit_idx_q  <= digit_idx_d;
      pwm_cnt_q    <= pwm_cnt_d;
      first_q      <= first_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_lz_q      <= sh_lz_d;
      sh_bright_q  <= sh_bright_d;
      cat_q        <= cat_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    logic dwell_wrap;
    logic frame_wrap;
    logic dark;
    logic pwm_on;

    dwell_cnt_d  = dwell_cnt_q + DWELL_W'(1);
    digit_idx_d  = digit_idx_q;
    pwm_cnt_d    = pwm_cnt_q + BRIGHT_W'(1);
    first_d      = 1'b0;
    sh_val_d     = sh_val_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    sh_lz_d      = sh_lz_q;
    sh_bright_d  = sh_bright_q;
    cat_d        = SEG_OFF;
    dp_d         = 1'b1;
    an_d         = '1;
    frame_done_d = 1'b0;

    dwell_wrap = (dwell_cnt_q == DWELL_W'(COUNT_TO - 1));
    frame_wrap = dwell_wrap && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));

    if (dwell_wrap) begin
      dwell_cnt_d = '0;
      digit_idx_d = frame_wrap ? '0 : digit_idx_q + IDX_W'(1);
    end

    // Shadow load whenever digit_idx enters 0, so a frame never mixes values
    if (first_q || frame_wrap) begin
      sh_val_d    = val_in;
      sh_dp_d     = dp_in;
      sh_blank_d  = blank_in;
      sh_lz_d     = lz_suppress_in;
      sh_bright_d = brightness_in;
    end

    // dwell_cnt == 0 is the ghost guard cycle
    dark   = (dwell_cnt_q == '0) || sh_blank_q[digit_idx_q] ||
             (sh_lz_q && lz_vec_c[digit_idx_q]);
    pwm_on = (sh_bright_q > pwm_cnt_q) || (&sh_bright_q);

    if (!dark) begin
      cat_d = cur_seg_n_c;
      dp_d  = ~sh_dp_q[digit_idx_q];
      if (pwm_on) begin
        an_d[digit_idx_q] = 1'b0;
      end
    end

    frame_done_d = frame_wrap;
  end

  assign cat_out        = cat_q;
  assign dp_out         = dp_q;
  assign an_out         = an_q;
  assign frame_done_out = frame_done_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed scoreboard bench for seven_segment_mux with 4 digits, dwell 4.
module tb_seven_segment_mux;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] cat;
    logic       dp;
    logic       fd;
  } out_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] val_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_suppress_in;
  logic [3:0]  brightness_in;
  logic [6:0]  cat_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done_out;

  int errors = 0;
  int checks = 0;
  int k      = 0;
  int lit_cnt = 0;
  out_t sb[$];

  logic [15:0] m_val;
  logic [3:0]  m_dp, m_blank, m_bright;
  logic        m_lz;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_segment_mux #(.NUM_DIGITS(4), .COUNT_TO(4), .BRIGHT_W(4)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .val_in         (val_in),
    .dp_in          (dp_in),
    .blank_in       (blank_in),
    .lz_suppress_in (lz_suppress_in),
    .brightness_in  (brightness_in),
    .cat_out        (cat_out),
    .dp_out         (dp_out),
    .an_out         (an_out),
    .frame_done_out (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  // Expected outputs after the k-th clock edge since reset release
  function automatic out_t model_out(int kk);
    out_t        r;
    int          c, dwell, idx, pwm;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        supp;
    c     = kk - 1;
    dwell = c % 4;
    idx   = (c / 4) % 4;
    pwm   = c % 16;
    upper = m_val >> (4 * idx);
    nib   = upper[3:0];
    supp  = m_lz && (idx >= 1) && (upper == 16'h0000);
    r.fd  = ((c % 16) == 15);
    r.an  = 4'hF;
    r.cat = 7'h7F;
    r.dp  = 1'b1;
    if (!(dwell == 0 || m_blank[idx] || supp)) begin
      r.cat = ~font[nib];
      r.dp  = ~m_dp[idx];
      if (m_bright == 4'hF || int'(m_bright) > pwm) r.an[idx] = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    out_t obs, exp;
    @(posedge clk_in);
    k++;
    if (k == 1 || (k % 16) == 0) begin
      m_val    = val_in;
      m_dp     = dp_in;
      m_blank  = blank_in;
      m_lz     = lz_suppress_in;
      m_bright = brightness_in;
    end
    sb.push_back(model_out(k + 1));
    #1;
    obs = {an_out, cat_out, dp_out, frame_done_out};
    if (an_out != 4'hF) lit_cnt++;
    if (sb.size() < 2) begin
      check($sformatf("sb_empty_c%0d", k), 13'(sb.size()), 13'd2);
    end else begin
      exp = sb.pop_front();
      check($sformatf("cycle%0d", k), obs, exp);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    k        = 0;
    m_val    = '0;
    m_dp     = '0;
    m_blank  = '0;
    m_lz     = 1'b0;
    m_bright = '0;
    sb.delete();
    sb.push_back(model_out(1));
  endtask

  initial begin
    rst_n_in       = 1'b0;
    val_in         = 16'h1234;
    dp_in          = 4'b0000;
    blank_in       = 4'b0000;
    lz_suppress_in = 1'b0;
    brightness_in  = 4'hF;
    #12;
    check("reset_outputs", {an_out, cat_out, dp_out, frame_done_out}, {4'hF, 7'h7F, 1'b1, 1'b0});
    release_reset();

    // Scan order 4,3,2,1 with frame_done every 16 cycles
    steps(32);

    // Mid-frame change while digit 2 is shown stays hidden until next frame
    steps(9);
    val_in = 16'hABCD;
    steps(23);

    // Leading zeros
    val_in         = 16'h0050;
    lz_suppress_in = 1'b1;
    steps(32);
    val_in = 16'h0000;
    steps(32);

    // Decimal points and blanking
    val_in         = 16'h1234;
    lz_suppress_in = 1'b0;
    dp_in          = 4'b0010;
    blank_in       = 4'b0100;
    steps(32);

    // Brightness 0: dark for a full frame
    dp_in         = 4'b0000;
    blank_in      = 4'b0000;
    brightness_in = 4'h0;
    steps(16);
    lit_cnt = 0;
    steps(16);
    check("bright0_lit", 13'(lit_cnt), 13'd0);

    // Brightness 4: pwm phase 0 always lands on a guard cycle, leaving 3 lit
    brightness_in = 4'h4;
    steps(16);
    lit_cnt = 0;
    steps(16);
    check("bright4_lit", 13'(lit_cnt), 13'd3);

    // Asynchronous reset mid-digit, then restart with a fresh snapshot
    brightness_in = 4'hF;
    steps(6);
    #1 rst_n_in = 1'b0;
    #1;
    check("async_reset", {an_out, cat_out, dp_out, frame_done_out}, {4'hF, 7'h7F, 1'b1, 1'b0});
    val_in = 16'h5678;
    @(negedge clk_in);
    release_reset();
    steps(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
